// File: rtl/msdap_pkg.sv
// Shared definitions for the MSDAP term feeder.
// Holds the data/table dimensions, the FSM state encodings reported on the
// status port, the field positions inside a coefficient config word and the
// packed layout of one coefficient table entry.
package msdap_pkg;

  localparam int DATA_W     = 16;
  localparam int HIST_DEPTH = 256;
  localparam int NUM_RJ     = 16;
  localparam int NUM_COEFF  = 512;

  localparam int HIST_AW  = $clog2(HIST_DEPTH);  // delay / ring address width
  localparam int RJ_W     = $clog2(NUM_RJ);      // group index width
  localparam int COEFF_AW = $clog2(NUM_COEFF);   // coefficient index width
  localparam int SUM_W    = 12;                  // holds 16 * 255

  // Coefficient config word fields
  localparam int SIGN_BIT = 8;
  localparam int K_MSB    = 7;

  // FSM encodings, visible on the status port
  localparam logic [2:0] ST_LOAD_RJ    = 3'd0;
  localparam logic [2:0] ST_LOAD_COEFF = 3'd1;
  localparam logic [2:0] ST_WAIT       = 3'd2;
  localparam logic [2:0] ST_EMIT       = 3'd3;
  localparam logic [2:0] ST_ERROR      = 3'd7;

  typedef struct packed {
    logic               sign;  // 1 = coefficient negative
    logic [HIST_AW-1:0] k;     // delay of the referenced sample
  } coeff_t;

endpackage

// File: rtl/msdap_hist_ring.sv
// Circular history of input samples.
//  clk, reset  : clock, synchronous active-high reset (clears history)
//  wr_en       : store wr_data as the newest sample x[n]
//  wr_data     : sample value
//  delay       : k, read x[n-k] relative to the most recent write
//  rd_data     : x[n-k], or 0 when fewer than k+1 samples have been stored
module msdap_hist_ring
  import msdap_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [HIST_AW-1:0] delay,
  output logic [DATA_W-1:0]  rd_data
);

  logic [DATA_W-1:0]  mem [HIST_DEPTH];
  logic [HIST_AW-1:0] wr_ptr;
  logic [HIST_AW-1:0] last_ptr;  // address holding x[n]
  logic [HIST_AW:0]   fill;      // samples stored, saturates at HIST_DEPTH
  logic [HIST_AW-1:0] rd_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < HIST_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      last_ptr <= '0;
      fill     <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      last_ptr    <= wr_ptr;
      wr_ptr      <= (wr_ptr == HIST_AW'(HIST_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (fill != (HIST_AW + 1)'(HIST_DEPTH)) fill <= fill + 1'b1;
    end
  end

  // Modulo arithmetic on the address width gives the wrap-around read.
  assign rd_addr = last_ptr - delay;
  assign rd_data = ({1'b0, delay} >= fill) ? '0 : mem[rd_addr];

endmodule

// File: rtl/msdap_term_feeder.sv
// MSDAP term feeder: loads the rj group-size table and the signed coefficient
// table, then for each accepted sample streams every term x[n-k] with its
// coefficient sign, group by group, to the u_j accumulator.
//  cfgWord/cfgValid/cfgReady       : table load (rj phase, then coeff phase)
//  sampleIn/sampleValid/sampleReady: new sample, taken only while idle
//  inData/inCoeffSign/validData    : current term, registered, held until taken
//  readyForData                    : term transfers on validData & readyForData
//  readyForCoeffSign               : sign strobe, must never be high without validData
//  groupLast                       : current term closes its group
//  status                          : FSM state (0 rj,1 coeff,2 wait,3 emit,7 error)
// Handshake: a transfer happens at a rising edge where valid and ready are both
// high; valid and its payload stay constant until that edge, and the sender
// never withdraws valid before the transfer.
module msdap_term_feeder
  import msdap_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cfgWord,
  input  logic              cfgValid,
  output logic              cfgReady,
  input  logic [DATA_W-1:0] sampleIn,
  input  logic              sampleValid,
  output logic              sampleReady,
  output logic [DATA_W-1:0] inData,
  output logic              validData,
  output logic              inCoeffSign,
  input  logic              readyForData,
  input  logic              readyForCoeffSign,
  output logic              groupLast,
  output logic [2:0]        status
);

  logic [2:0]          state;
  logic [7:0]          rj_tab [NUM_RJ];
  coeff_t              coeff_tab [NUM_COEFF];
  logic [RJ_W-1:0]     rj_idx;
  logic [COEFF_AW-1:0] coeff_idx;
  logic [SUM_W-1:0]    rj_sum;
  logic [RJ_W-1:0]     grp;
  logic [7:0]          term;
  logic [COEFF_AW-1:0] cp;        // coefficient of the current term
  logic                vd_q, sign_q, last_q;
  logic [DATA_W-1:0]   data_q;

  logic                cfg_fire, sample_fire;
  logic [SUM_W-1:0]    next_sum;
  logic [7:0]          cur_rj;
  coeff_t              cur_coeff;
  logic                cur_empty, cur_last;
  logic [DATA_W-1:0]   ring_data;
  logic                cfg_unused;

  assign cfg_unused  = ^cfgWord[15:9];
  assign cfgReady    = (state == ST_LOAD_RJ) || (state == ST_LOAD_COEFF);
  assign sampleReady = (state == ST_WAIT);
  assign cfg_fire    = cfgValid & cfgReady;
  assign sample_fire = sampleValid & sampleReady;
  assign next_sum    = rj_sum + SUM_W'(cfgWord[7:0]);

  assign cur_rj    = rj_tab[grp];
  assign cur_coeff = coeff_tab[cp];
  // An empty group still emits one zero term so the downstream group count holds.
  assign cur_empty = (cur_rj == 8'd0);
  assign cur_last  = cur_empty || (term == cur_rj - 8'd1);

  msdap_hist_ring u_ring (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (sample_fire),
    .wr_data (sampleIn),
    .delay   (cur_coeff.k),
    .rd_data (ring_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOAD_RJ;
      for (int i = 0; i < NUM_RJ; i++)    rj_tab[i]    <= '0;
      for (int i = 0; i < NUM_COEFF; i++) coeff_tab[i] <= '0;
      rj_idx    <= '0;
      coeff_idx <= '0;
      rj_sum    <= '0;
      grp       <= '0;
      term      <= '0;
      cp        <= '0;
      vd_q      <= 1'b0;
      sign_q    <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      case (state)
        ST_LOAD_RJ: if (cfg_fire) begin
          rj_tab[rj_idx] <= cfgWord[7:0];
          rj_sum         <= next_sum;
          rj_idx         <= rj_idx + 1'b1;
          if (rj_idx == RJ_W'(NUM_RJ - 1)) begin
            if (next_sum > SUM_W'(NUM_COEFF)) state <= ST_ERROR;
            else if (next_sum == '0)          state <= ST_WAIT;
            else                              state <= ST_LOAD_COEFF;
          end
        end
        ST_LOAD_COEFF: if (cfg_fire) begin
          coeff_tab[coeff_idx] <= '{sign: cfgWord[SIGN_BIT], k: cfgWord[K_MSB:0]};
          coeff_idx            <= coeff_idx + 1'b1;
          if (SUM_W'(coeff_idx) == rj_sum - SUM_W'(1)) state <= ST_WAIT;
        end
        ST_WAIT: if (sample_fire) begin
          state <= ST_EMIT;
          grp   <= '0;
          term  <= '0;
          cp    <= '0;
        end
        ST_EMIT: begin
          if (!vd_q) begin
            // Present the term selected by grp/term/cp; the history already
            // contains x[n] because the write happened on the accept edge.
            vd_q   <= 1'b1;
            data_q <= cur_empty ? '0 : ring_data;
            sign_q <= cur_empty ? 1'b0 : cur_coeff.sign;
            last_q <= cur_last;
          end else if (readyForData) begin
            vd_q <= 1'b0;
            if (!cur_empty) cp <= cp + 1'b1;
            if (cur_last) begin
              term <= '0;
              if (grp == RJ_W'(NUM_RJ - 1)) state <= ST_WAIT;
              else                          grp   <= grp + 1'b1;
            end else begin
              term <= term + 1'b1;
            end
          end
        end
        default: ;  // ST_ERROR is sticky until reset
      endcase

      // Sign strobe without a valid term is a protocol violation.
      if (readyForCoeffSign && !vd_q && state != ST_ERROR) begin
        state <= ST_ERROR;
        vd_q  <= 1'b0;
      end
    end
  end

  assign inData      = data_q;
  assign validData   = vd_q;
  assign inCoeffSign = sign_q;
  assign groupLast   = last_q;
  assign status      = state;

endmodule

// File: tb/tb_msdap_term_feeder.sv
// Self-checking bench for msdap_term_feeder: table-driven sample/term vectors
// plus directed sequences for hold, wrap-around, empty groups, errors and reset.
module tb_msdap_term_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cfgWord;
  logic        cfgValid;
  logic        cfgReady;
  logic [15:0] sampleIn;
  logic        sampleValid;
  logic        sampleReady;
  logic [15:0] inData;
  logic        validData;
  logic        inCoeffSign;
  logic        readyForData;
  logic        readyForCoeffSign;
  logic        groupLast;
  logic [2:0]  status;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] sample;
    logic [15:0] exp_k0;
    logic [15:0] exp_k1;
  } vec_t;
  vec_t tab [4];

  logic [15:0] rj_cfg [16];
  logic [15:0] co_cfg [$];

  msdap_term_feeder dut (
    .clk               (clk),
    .reset             (reset),
    .cfgWord           (cfgWord),
    .cfgValid          (cfgValid),
    .cfgReady          (cfgReady),
    .sampleIn          (sampleIn),
    .sampleValid       (sampleValid),
    .sampleReady       (sampleReady),
    .inData            (inData),
    .validData         (validData),
    .inCoeffSign       (inCoeffSign),
    .readyForData      (readyForData),
    .readyForCoeffSign (readyForCoeffSign),
    .groupLast         (groupLast),
    .status            (status)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [15:0] w);
    cfgWord  = w;
    cfgValid = 1'b1;
    @(negedge clk);
    cfgValid = 1'b0;
  endtask

  task automatic load_cfg();
    for (int i = 0; i < 16; i++) cfg_write(rj_cfg[i]);
    foreach (co_cfg[i]) cfg_write(co_cfg[i]);
  endtask

  // Accept on the next rising edge, then check the two-cycle latency.
  task automatic send_sample(input logic [15:0] x);
    check("sample_ready", sampleReady, 1'b1);
    sampleIn    = x;
    sampleValid = 1'b1;
    @(negedge clk);
    sampleValid = 1'b0;
    check("emit_entry_status", status, 3'd3);
    check("emit_entry_valid", validData, 1'b0);
    @(negedge clk);
    check("first_term_latency", validData, 1'b1);
  endtask

  task automatic take_term(output logic [15:0] d, output logic s, output logic l);
    int n;
    n = 0;
    while (!validData && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!validData) begin
      n_cmp++;
      n_err++;
      $display("FAIL take_term_timeout: validData=0 required 1");
      d = '0; s = 1'b0; l = 1'b0;
    end else begin
      d = inData; s = inCoeffSign; l = groupLast;
      readyForData = 1'b1;
      @(negedge clk);
      readyForData = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] d;
    logic        s, l;

    tab[0] = '{16'h0004, 16'h0004, 16'h0000};
    tab[1] = '{16'h1234, 16'h1234, 16'h0004};
    tab[2] = '{16'hFFFF, 16'hFFFF, 16'h1234};
    tab[3] = '{16'h8000, 16'h8000, 16'hFFFF};

    reset = 1'b1; cfgWord = '0; cfgValid = 1'b0; sampleIn = '0; sampleValid = 1'b0;
    readyForData = 1'b0; readyForCoeffSign = 1'b0;
    do_reset();

    // Reset state
    check("rst_status", status, 3'd0);
    check("rst_cfg_ready", cfgReady, 1'b1);
    check("rst_sample_ready", sampleReady, 1'b0);
    check("rst_valid", validData, 1'b0);
    check("rst_data", inData, 16'h0);
    check("rst_sign", inCoeffSign, 1'b0);
    check("rst_last", groupLast, 1'b0);

    // Config A: every group rj=2, coeffs k=0 then k=1, sign 0
    for (int i = 0; i < 16; i++) rj_cfg[i] = 16'd2;
    co_cfg.delete();
    for (int g = 0; g < 16; g++) begin
      co_cfg.push_back(16'h0000);
      co_cfg.push_back(16'h0001);
    end
    load_cfg();
    check("cfgA_status", status, 3'd2);
    check("cfgA_cfg_ready", cfgReady, 1'b0);
    check("cfgA_sample_ready", sampleReady, 1'b1);

    // Table-driven samples; a spurious sample is offered during each emission
    for (int v = 0; v < 4; v++) begin
      send_sample(tab[v].sample);
      for (int g = 0; g < 16; g++) begin
        take_term(d, s, l);
        check("tab_k0_data", d, tab[v].exp_k0);
        check("tab_k0_sign", s, 1'b0);
        check("tab_k0_last", l, 1'b0);
        if (g == 0) begin
          sampleIn = 16'h7777;
          sampleValid = 1'b1;
          check("emit_sample_ready", sampleReady, 1'b0);
        end
        take_term(d, s, l);
        check("tab_k1_data", d, tab[v].exp_k1);
        check("tab_k1_sign", s, 1'b0);
        check("tab_k1_last", l, 1'b1);
      end
      sampleValid = 1'b0;
      check("tab_done_status", status, 3'd2);
      check("tab_done_valid", validData, 1'b0);
    end

    // Reset in the middle of an emission
    send_sample(16'h5555);
    take_term(d, s, l); check("mid_g0t0", d, 16'h5555);
    take_term(d, s, l); check("mid_g0t1", d, 16'h8000);
    take_term(d, s, l); check("mid_g1t0", d, 16'h5555);
    @(negedge clk);
    check("mid_valid_before_reset", validData, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", validData, 1'b0);
    check("mid_rst_status", status, 3'd0);
    check("mid_rst_cfg_ready", cfgReady, 1'b1);
    reset = 1'b0;

    // Config B: rj=1 except rj[3]=0; g0 sign1 k0, g1 k1, g2 k255, others k0
    do_reset();
    for (int i = 0; i < 16; i++) rj_cfg[i] = (i == 3) ? 16'd0 : 16'd1;
    co_cfg.delete();
    co_cfg.push_back(16'h0100);
    co_cfg.push_back(16'h0001);
    co_cfg.push_back(16'h00FF);
    for (int g = 4; g < 16; g++) co_cfg.push_back(16'h0000);
    load_cfg();
    check("cfgB_status", status, 3'd2);

    send_sample(16'h8000);
    for (int c = 0; c < 10; c++) begin
      check("hold_valid", validData, 1'b1);
      check("hold_data", inData, 16'h8000);
      check("hold_sign", inCoeffSign, 1'b1);
      @(negedge clk);
    end
    take_term(d, s, l);
    check("b_g0_data", d, 16'h8000); check("b_g0_sign", s, 1'b1); check("b_g0_last", l, 1'b1);
    take_term(d, s, l);
    check("b_g1_unfilled", d, 16'h0000); check("b_g1_last", l, 1'b1);
    take_term(d, s, l);
    check("b_g2_unfilled", d, 16'h0000);
    take_term(d, s, l);
    check("b_g3_empty_data", d, 16'h0000); check("b_g3_empty_sign", s, 1'b0);
    check("b_g3_empty_last", l, 1'b1);
    for (int g = 4; g < 16; g++) begin
      take_term(d, s, l);
      check("b_gx_data", d, 16'h8000); check("b_gx_sign", s, 1'b0); check("b_gx_last", l, 1'b1);
    end
    check("b_done_status", status, 3'd2);

    // 300 further samples: wrap the history, check k=0,1,255 on the last one
    for (int i = 0; i < 300; i++) begin
      send_sample(16'h0100 + 16'(i));
      for (int g = 0; g < 16; g++) begin
        take_term(d, s, l);
        if (i == 299 && g == 0) begin
          check("wrap_k0", d, 16'h022B); check("wrap_k0_sign", s, 1'b1);
        end
        if (i == 299 && g == 1) check("wrap_k1", d, 16'h022A);
        if (i == 299 && g == 2) check("wrap_k255", d, 16'h012C);
      end
    end

    // Sign strobe without valid data
    check("pre_rfcs_status", status, 3'd2);
    readyForCoeffSign = 1'b1;
    @(negedge clk);
    readyForCoeffSign = 1'b0;
    check("rfcs_err_status", status, 3'd7);
    check("rfcs_err_sample_ready", sampleReady, 1'b0);
    @(negedge clk);
    check("rfcs_err_sticky", status, 3'd7);

    // Config C: sum(rj)=600 exceeds the coefficient table
    do_reset();
    for (int i = 0; i < 16; i++) rj_cfg[i] = (i == 15) ? 16'd30 : 16'd38;
    co_cfg.delete();
    load_cfg();
    check("sum_err_status", status, 3'd7);
    check("sum_err_cfg_ready", cfgReady, 1'b0);
    cfg_write(16'h0001);
    check("sum_err_sticky", status, 3'd7);
    check("sum_err_valid", validData, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
